// File: rtl/rx_byte_buffer_pkg.sv
// rtl/rx_byte_buffer_pkg.sv - shared constants and helpers for the receive byte buffer
package rx_byte_buffer_pkg;

    localparam int POLICY_DROP      = 0;
    localparam int POLICY_OVERWRITE = 1;

    // Ceiling log2, used to size pointers from DEPTH
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_buf_mem.sv
// rtl/rx_buf_mem.sv - DEPTH x DATA_W storage with one write port and registered pop/peek reads
module rx_buf_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              pk_en,
    input  logic              pk_hit,
    input  logic [ADDR_W-1:0] pk_addr,
    output logic [DATA_W-1:0] pk_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered reads see pre-write contents, so a pop at full returns the oldest word
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata   <= '0;
            pk_data <= '0;
        end else begin
            if (re) begin
                rdata <= mem[raddr];
            end
            if (pk_en) begin
                pk_data <= pk_hit ? mem[pk_addr] : '0;
            end
        end
    end

endmodule

// File: rtl/rx_byte_buffer.sv
// rtl/rx_byte_buffer.sv - circular receive buffer with pop port, peek port and sticky flags
module rx_byte_buffer
    import rx_byte_buffer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = clog2(DEPTH),
    parameter int OVERWRITE = POLICY_DROP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic [ADDR_W-1:0] peek_addr,
    output logic [DATA_W-1:0] peek_data,
    output logic              peek_hit,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam bit                OVW_MODE  = (OVERWRITE == POLICY_OVERWRITE);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] pk_addr;
    logic              do_pop;
    logic              wr_blocked;
    logic              wr_ovw;
    logic              mem_we;
    logic              mem_re;
    logic              pk_en;
    logic              pk_hit;
    logic              cnt_inc;

    assign full  = (count == COUNT_MAX);
    assign empty = (count == '0);

    // Decode this cycle's accepted operations; a pop at full frees the slot the write needs
    always_comb begin
        do_pop     = rd_en && !empty;
        wr_blocked = full && !do_pop;
        wr_ovw     = wr_en && wr_blocked && OVW_MODE;
        mem_we     = wr_en && !clr && (!wr_blocked || OVW_MODE);
        mem_re     = do_pop && !clr;
        pk_en      = !clr;
        pk_addr    = rd_ptr + peek_addr;
        pk_hit     = ({1'b0, peek_addr} < count);
        cnt_inc    = mem_we && !wr_ovw;
    end

    // Pointer, occupancy and flag state; reset beats clr, clr beats traffic
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            peek_hit  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            peek_hit  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (mem_we) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop || wr_ovw) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count    <= count + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, do_pop};
            rd_valid <= do_pop;
            peek_hit <= pk_hit;
            if (wr_en && wr_blocked) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    rx_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we),
        .waddr   (wr_ptr),
        .wdata   (wr_data),
        .re      (mem_re),
        .raddr   (rd_ptr),
        .rdata   (rd_data),
        .pk_en   (pk_en),
        .pk_hit  (pk_hit),
        .pk_addr (pk_addr),
        .pk_data (peek_data)
    );

endmodule

// File: tb/tb_rx_byte_buffer.sv
// tb/tb_rx_byte_buffer.sv - directed self-checking bench for rx_byte_buffer
module tb_rx_byte_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [1:0] peek_addr;

    logic [7:0] rd_data0, rd_data1, peek_data0, peek_data1;
    logic       rd_valid0, rd_valid1, peek_hit0, peek_hit1;
    logic [2:0] count0, count1;
    logic       full0, full1, empty0, empty1;
    logic       overflow0, overflow1, underflow0, underflow1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Drop-policy instance
    rx_byte_buffer #(.DATA_W(8), .DEPTH(4), .ADDR_W(2), .OVERWRITE(0)) u_drop (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .peek_addr(peek_addr), .peek_data(peek_data0), .peek_hit(peek_hit0),
        .count(count0), .full(full0), .empty(empty0),
        .overflow(overflow0), .underflow(underflow0)
    );

    // Overwrite-policy instance fed the same stimulus
    rx_byte_buffer #(.DATA_W(8), .DEPTH(4), .ADDR_W(2), .OVERWRITE(1)) u_ovw (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .peek_addr(peek_addr), .peek_data(peek_data1), .peek_hit(peek_hit1),
        .count(count1), .full(full1), .empty(empty1),
        .overflow(overflow1), .underflow(underflow1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [7:0] wd, input logic r, input logic c);
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        clr     = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; peek_addr = 2'd0;

        // Reset state
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_count", count0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_rd_valid", rd_valid0, 0);
        chk("rst_rd_data", rd_data0, 8'h00);
        chk("rst_peek_hit", peek_hit0, 0);
        chk("rst_peek_data", peek_data0, 8'h00);
        chk("rst_flags", {overflow0, underflow0, overflow1, underflow1}, 4'b0000);
        reset = 1'b1;

        // Fill and drain
        cyc(1'b1, 8'h41, 1'b0, 1'b0);
        cyc(1'b1, 8'h42, 1'b0, 1'b0);
        cyc(1'b1, 8'h43, 1'b0, 1'b0);
        cyc(1'b1, 8'h44, 1'b0, 1'b0);
        chk("fill_count", count0, 4);
        chk("fill_full", full0, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop1_data", rd_data0, 8'h41);
        chk("pop1_valid", rd_valid0, 1);
        chk("pop1_count", count0, 3);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop2_data", rd_data0, 8'h42);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop3_data", rd_data0, 8'h43);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop4_data", rd_data0, 8'h44);
        chk("pop4_valid", rd_valid0, 1);
        chk("drain_count", count0, 0);
        chk("drain_empty", empty0, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_valid", rd_valid0, 0);
        chk("idle_hold", rd_data0, 8'h44);

        // Full policies: 0x10..0x15 into both instances
        cyc(1'b1, 8'h10, 1'b0, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h12, 1'b0, 1'b0);
        cyc(1'b1, 8'h13, 1'b0, 1'b0);
        chk("pol_ovf_before", {overflow0, overflow1}, 2'b00);
        cyc(1'b1, 8'h14, 1'b0, 1'b0);
        chk("drop_count", count0, 4);
        chk("drop_full", full0, 1);
        chk("drop_ovf", overflow0, 1);
        chk("ovw_count", count1, 4);
        chk("ovw_ovf", overflow1, 1);
        cyc(1'b1, 8'h15, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drop_pop1", rd_data0, 8'h10);
        chk("ovw_pop1", rd_data1, 8'h12);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drop_pop2", rd_data0, 8'h11);
        chk("ovw_pop2", rd_data1, 8'h13);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drop_pop3", rd_data0, 8'h12);
        chk("ovw_pop3", rd_data1, 8'h14);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drop_pop4", rd_data0, 8'h13);
        chk("ovw_pop4", rd_data1, 8'h15);
        chk("pol_empty", {empty0, empty1}, 2'b11);

        // Pop on empty together with a write
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("uf_valid", {rd_valid0, rd_valid1}, 2'b00);
        chk("uf_flag", {underflow0, underflow1}, 2'b11);
        chk("uf_count", count0, 1);
        chk("uf_hold", {rd_data0, rd_data1}, 16'h1315);

        // Flush with a concurrent write
        cyc(1'b1, 8'h99, 1'b0, 1'b1);
        chk("clr_count", {count0, count1}, 6'd0);
        chk("clr_flags", {overflow0, underflow0, overflow1, underflow1}, 4'b0000);
        chk("clr_hold", {rd_data0, rd_data1}, 16'h1315);
        chk("clr_peek_hit", peek_hit0, 0);

        // Simultaneous pop and write at full
        cyc(1'b1, 8'hA0, 1'b0, 1'b0);
        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0);
        cyc(1'b1, 8'hA3, 1'b0, 1'b0);
        cyc(1'b1, 8'hB0, 1'b1, 1'b0);
        chk("fullrw_data", {rd_data0, rd_data1}, 16'hA0A0);
        chk("fullrw_count", {count0, count1}, {3'd4, 3'd4});
        chk("fullrw_ovf", {overflow0, overflow1}, 2'b00);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullrw_next", {rd_data0, rd_data1}, 16'hA1A1);

        // Build a wrapped buffer holding 0x21..0x23 starting at slot 3
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'hE0, 1'b0, 1'b0);
        cyc(1'b1, 8'hE1, 1'b0, 1'b0);
        cyc(1'b1, 8'hE2, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_peek_pop", rd_data0, 8'hE2);
        cyc(1'b1, 8'h21, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h23, 1'b0, 1'b0);
        chk("peek_count", count0, 3);
        peek_addr = 2'd2;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("peek2_data", {peek_data0, peek_data1}, 16'h2323);
        chk("peek2_hit", {peek_hit0, peek_hit1}, 2'b11);
        peek_addr = 2'd0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("peek0_data", peek_data0, 8'h21);
        peek_addr = 2'd3;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("peek3_data", peek_data0, 8'h00);
        chk("peek3_hit", peek_hit0, 0);

        // Reset under traffic beats everything
        peek_addr = 2'd1;
        reset = 1'b0;
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("rst2_count", {count0, count1}, 6'd0);
        chk("rst2_rd", {rd_data0, rd_valid0}, 9'd0);
        chk("rst2_peek", {peek_data0, peek_hit0}, 9'd0);
        chk("rst2_flags", {overflow0, underflow0, empty0, full0}, 4'b0010);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
